// File: rtl/program_counter_unit_if.sv
// Fetch-stage bus of program_counter_unit: redirect controls from execute, fetch request to imem.
// PROGRAM_COUNTER_COMPRESSED_EN adds the compressed input for 16-bit instructions.
interface program_counter_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch;
  logic [XLEN-1:0] immediate;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            fetch_ready;
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
  logic            compressed;
`endif
  logic            fetch_valid;
  logic [XLEN-1:0] program_counter;
  logic [XLEN-1:0] program_counter_plus_4;
  logic            misaligned;
  logic [XLEN-1:0] fault_address;

  // master is the PC unit itself; slave is whoever drives redirects and consumes the request.
  modport master (
    input  stall, branch, immediate, jump, jump_target, trap, fetch_ready,
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    input  compressed,
`endif
    output fetch_valid, program_counter, program_counter_plus_4, misaligned, fault_address
  );

  modport slave (
    output stall, branch, immediate, jump, jump_target, trap, fetch_ready,
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    output compressed,
`endif
    input  fetch_valid, program_counter, program_counter_plus_4, misaligned, fault_address
  );
endinterface

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter with trap/jump/branch redirects and a misaligned-target fault state.
// Defining PROGRAM_COUNTER_COMPRESSED_EN enables 2-byte steps and 2-byte target alignment.
module program_counter_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input logic                    clock,
  input logic                    reset,
  program_counter_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fault_address;
  logic            fetch_valid;
  logic            misaligned;
  logic [XLEN-1:0] candidate;
  logic [XLEN-1:0] seq_step;
  logic            candidate_bad;

  if (XLEN < 8) begin : g_bad_xlen
    $error("program_counter_unit: XLEN must be at least 8");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("program_counter_unit: TRAP_VECTOR must be 4-byte aligned");
  end

  // Jump takes precedence over branch when both are raised in the same cycle.
  always_comb begin
    candidate = bus.jump ? (bus.jump_target & ~XLEN'(1))
                         : (pc + (bus.immediate << 1));
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    candidate_bad = candidate[0];
    seq_step      = bus.compressed ? XLEN'(2) : XLEN'(4);
`else
    candidate_bad = (candidate[1:0] != 2'b00);
    seq_step      = XLEN'(4);
`endif
  end

  // Trap is checked before the state so it also leaves BOOT and FAULT and beats stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      state         <= BOOT;
      fetch_valid   <= 1'b0;
      misaligned    <= 1'b0;
      fault_address <= '0;
    end else if (bus.trap) begin
      pc          <= TRAP_VECTOR;
      state       <= RUN;
      fetch_valid <= 1'b1;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (bus.stall) begin
            pc <= pc;
          end else if (bus.jump || bus.branch) begin
            if (candidate_bad) begin
              fault_address <= candidate;
              misaligned    <= 1'b1;
              fetch_valid   <= 1'b0;
              state         <= FAULT;
            end else begin
              pc <= candidate;
            end
          end else if (fetch_valid && bus.fetch_ready) begin
            pc <= pc + seq_step;
          end
        end
        FAULT: begin
          pc <= pc;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          misaligned  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.program_counter        = pc;
  assign bus.program_counter_plus_4 = pc + XLEN'(4);
  assign bus.fetch_valid            = fetch_valid;
  assign bus.misaligned             = misaligned;
  assign bus.fault_address          = fault_address;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: directed vector table, hand sequences,
// and randomized traffic against a behavioural model of the fetch PC.
module tb_program_counter_unit;

`ifdef PROGRAM_COUNTER_COMPRESSED_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        branch;
    logic        jump;
    logic        trap;
    logic        ready;
    logic        comp;
    logic [31:0] imm;
    logic [31:0] jt;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_fa;
  } vec_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  program_counter_unit_if #(.XLEN(32)) bus32 ();
  program_counter_unit_if #(.XLEN(8))  bus8 ();

  program_counter_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)
  ) dut32 (
    .clock(clock), .reset(reset), .bus(bus32.master)
  );

  program_counter_unit #(
    .XLEN(8), .RESET_VECTOR(8'h10), .TRAP_VECTOR(8'h40)
  ) dut8 (
    .clock(clock), .reset(reset), .bus(bus8.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state, expressed with the specification's terms.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_fa;
  localparam int M_BOOT = 0, M_RUN = 1, M_FAULT = 2;

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = 32'h0;
    m_fa   = 32'h0;
  endtask

  task automatic model_step(input in_t s);
    logic [31:0] target;
    int          align;
    align = (COMP_EN) ? 2 : 4;
    if (s.trap) begin
      m_pc   = 32'h100;
      m_mode = M_RUN;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && !s.stall) begin
      if (s.jump || s.branch) begin
        target = s.jump ? {s.jt[31:1], 1'b0} : m_pc + s.imm * 2;
        if (target % align != 0) begin
          m_fa   = target;
          m_mode = M_FAULT;
        end else begin
          m_pc = target;
        end
      end else if (s.ready) begin
        m_pc = m_pc + ((COMP_EN && s.comp) ? 32'd2 : 32'd4);
      end
    end
  endtask

  task automatic applyStimulus(input in_t s);
    bus32.stall       = s.stall;
    bus32.branch      = s.branch;
    bus32.jump        = s.jump;
    bus32.trap        = s.trap;
    bus32.fetch_ready = s.ready;
    bus32.immediate   = s.imm;
    bus32.jump_target = s.jt;
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    bus32.compressed  = s.comp;
`endif
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAll32(input logic [31:0] pc, input logic valid, input logic mis, input logic [31:0] fa);
    checkOutput("pc", bus32.program_counter, pc);
    checkOutput("pc_plus_4", bus32.program_counter_plus_4, pc + 32'd4);
    checkOutput("fetch_valid", {31'b0, bus32.fetch_valid}, {31'b0, valid});
    checkOutput("misaligned", {31'b0, bus32.misaligned}, {31'b0, mis});
    checkOutput("fault_address", bus32.fault_address, fa);
  endtask

  vec_t vecs[$];

  task automatic addVec(input logic st, input logic br, input logic jp, input logic tr, input logic rd,
                        input logic cp, input logic [31:0] imm, input logic [31:0] jt,
                        input logic [31:0] pc, input logic v, input logic mis, input logic [31:0] fa);
    vec_t x;
    x.in.stall = st; x.in.branch = br; x.in.jump = jp; x.in.trap = tr;
    x.in.ready = rd; x.in.comp = cp; x.in.imm = imm; x.in.jt = jt;
    x.exp_pc = pc; x.exp_valid = v; x.exp_mis = mis; x.exp_fa = fa;
    vecs.push_back(x);
  endtask

  function automatic in_t idle_in();
    in_t s;
    s.stall = 0; s.branch = 0; s.jump = 0; s.trap = 0; s.ready = 0; s.comp = 0;
    s.imm = 0; s.jt = 0;
    return s;
  endfunction

  initial begin
    in_t s;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(idle_in());
    bus8.stall = 0; bus8.branch = 0; bus8.jump = 0; bus8.trap = 0; bus8.fetch_ready = 0;
    bus8.immediate = 8'h0; bus8.jump_target = 8'h0;
`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    bus8.compressed = 1'b0;
`endif

`ifdef PROGRAM_COUNTER_COMPRESSED_EN
    addVec(0,0,0,0,1,0, 32'h0, 32'h0,  32'h0,  1,0, 32'h0);
    addVec(0,0,0,0,1,1, 32'h0, 32'h0,  32'h2,  1,0, 32'h0);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0,  32'h6,  1,0, 32'h0);
    addVec(0,0,1,0,1,0, 32'h0, 32'h2A, 32'h2A, 1,0, 32'h0);
    addVec(0,1,0,0,0,0, 32'h1, 32'h0,  32'h2C, 1,0, 32'h0);
    addVec(0,0,1,0,0,0, 32'h0, 32'h43, 32'h42, 1,0, 32'h0);
    addVec(0,0,0,0,1,1, 32'h0, 32'h0,  32'h44, 1,0, 32'h0);
`else
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h0,  1,0, 32'h0);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h4,  1,0, 32'h0);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h8,  1,0, 32'h0);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'hC,  1,0, 32'h0);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h10, 1,0, 32'h0);
    addVec(0,0,0,0,0,0, 32'h0, 32'h0, 32'h10, 1,0, 32'h0);
    addVec(0,0,0,0,0,0, 32'h0, 32'h0, 32'h10, 1,0, 32'h0);
    addVec(0,0,0,0,0,0, 32'h0, 32'h0, 32'h10, 1,0, 32'h0);
    addVec(0,1,0,0,0,0, 32'hFFFFFFFC, 32'h0, 32'h8, 1,0, 32'h0);
    addVec(0,0,1,0,0,0, 32'h0, 32'h20, 32'h20, 1,0, 32'h0);
    addVec(1,0,1,0,1,0, 32'h0, 32'h41, 32'h20, 1,0, 32'h0);
    addVec(0,0,1,0,1,0, 32'h0, 32'h41, 32'h40, 1,0, 32'h0);
    addVec(0,0,1,0,1,0, 32'h0, 32'h42, 32'h40, 0,1, 32'h42);
    addVec(1,1,1,0,1,0, 32'h4, 32'h80, 32'h40, 0,1, 32'h42);
    addVec(0,0,1,0,1,0, 32'h0, 32'h80, 32'h40, 0,1, 32'h42);
    addVec(0,0,0,1,0,0, 32'h0, 32'h0, 32'h100, 1,0, 32'h42);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h104, 1,0, 32'h42);
    addVec(0,1,0,0,0,0, 32'h2, 32'h0, 32'h108, 1,0, 32'h42);
    addVec(0,1,0,0,0,0, 32'h1, 32'h0, 32'h108, 0,1, 32'h10A);
    addVec(1,0,0,1,0,0, 32'h0, 32'h0, 32'h100, 1,0, 32'h10A);
    addVec(0,0,1,0,0,0, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFC, 1,0, 32'h10A);
    addVec(0,0,0,0,1,0, 32'h0, 32'h0, 32'h0, 1,0, 32'h10A);
    addVec(0,1,1,0,0,0, 32'h30, 32'h20, 32'h20, 1,0, 32'h10A);
    addVec(0,1,0,0,0,0, 32'hFFFFFFFC, 32'h0, 32'h18, 1,0, 32'h10A);
`endif

    // Reset state, BOOT cycle visible before the first edge after release.
    @(posedge clock); #1;
    checkAll32(32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in);
      @(posedge clock); #1;
      checkAll32(vecs[i].exp_pc, vecs[i].exp_valid, vecs[i].exp_mis, vecs[i].exp_fa);
    end

    // Asynchronous reset mid-cycle, then trap taken straight out of BOOT.
    applyStimulus(idle_in());
    #3 reset = 1'b1;
    #1 checkAll32(32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    s = idle_in();
    s.trap = 1'b1;
    applyStimulus(s);
    @(posedge clock); #1;
    checkAll32(32'h100, 1'b1, 1'b0, 32'h0);

    // Randomized traffic against the model.
    applyStimulus(idle_in());
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      s.trap   = ($urandom_range(0, 19) == 0);
      s.stall  = ($urandom_range(0, 3) == 0);
      s.jump   = ($urandom_range(0, 7) == 0);
      s.branch = ($urandom_range(0, 7) == 0);
      s.ready  = $urandom_range(0, 1) != 0;
      s.comp   = $urandom_range(0, 1) != 0;
      s.imm    = 32'($urandom_range(0, 200)) - 32'd100;
      s.jt     = $urandom;
      if ($urandom_range(0, 1) == 0) s.jt[1:0] = 2'b00;
      applyStimulus(s);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1 checkAll32(m_pc, 1'b0, 1'b0, m_fa);
        @(posedge clock); #1;
        reset = 1'b0;
      end else begin
        @(posedge clock);
        model_step(s);
        #1 checkAll32(m_pc, m_mode == M_RUN, m_mode == M_FAULT, m_fa);
      end
    end

    // Narrow instance: wrap-around at 2^8 and asynchronous reset to its own vector.
    applyStimulus(idle_in());
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("pc8_reset", {24'b0, bus8.program_counter}, 32'h10);
    @(posedge clock); #1;
    bus8.jump = 1'b1;
    bus8.jump_target = 8'hFC;
    @(posedge clock); #1;
    checkOutput("pc8_jump", {24'b0, bus8.program_counter}, 32'hFC);
    bus8.jump = 1'b0;
    bus8.fetch_ready = 1'b1;
    @(posedge clock); #1;
    checkOutput("pc8_wrap", {24'b0, bus8.program_counter}, 32'h00);
    checkOutput("pc8_plus_4", {24'b0, bus8.program_counter_plus_4}, 32'h04);
    #3 reset = 1'b1;
    #1 checkOutput("pc8_async_reset", {24'b0, bus8.program_counter}, 32'h10);
    checkOutput("valid8_async_reset", {31'b0, bus8.fetch_valid}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
- Parameterised program counter and next-PC selection for the fetch stage.
- Generalises fixed 32-bit PC/branch logic: configurable width, reset and trap vectors, absolute jumps, stall, fetch valid/ready handshake, and a misaligned-target fault state machine.
- Sits between the execute stage (redirect sources) and instruction memory (fetch request).

Parameters:
- XLEN, 32, PC and data width in bits (>= 8).
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 'h100, PC value loaded on trap; must be 4-byte aligned (elaboration-time assertion).

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC; blocks sequential advance and branch/jump redirects.
- branch  input  1  conditional branch taken.
- immediate  input  XLEN  branch immediate in halfword units; target = pc + (immediate << 1).
- jump  input  1  absolute redirect.
- jump_target  input  XLEN  absolute target; bit 0 is cleared before use.
- trap  input  1  redirect to TRAP_VECTOR; overrides everything, including stall and the FAULT state.
- fetch_ready  input  1  instruction memory accepts the request at pc.
- fetch_valid  output  1  pc is a valid fetch request.
- program_counter  output  XLEN  current PC (registered).
- program_counter_plus_4  output  XLEN  program_counter + 4 (combinational, mod 2^XLEN).
- misaligned  output  1  registered; high while in FAULT.
- fault_address  output  XLEN  registered; offending target address.

Behaviour:
- Reset values (asynchronous): program_counter = RESET_VECTOR, state = BOOT, fetch_valid = 0, misaligned = 0, fault_address = 0.
- States:
  - BOOT: fetch_valid = 0; unconditionally goes to RUN on the next clock. The first request appears one cycle after reset deasserts.
  - RUN: fetch_valid = 1.
  - FAULT: fetch_valid = 0; misaligned = 1; program_counter frozen.
- Next-PC priority in RUN, evaluated each clock:
  1. trap: pc <= TRAP_VECTOR.
  2. stall: pc holds.
  3. jump: candidate = jump_target & ~1.
  4. branch: candidate = pc + (immediate << 1).
  5. fetch_valid && fetch_ready: pc <= pc + 4.
  6. Otherwise pc holds.
- Redirects (trap, jump, branch) do not require fetch_ready; they abandon any outstanding request.
- Alignment check on jump and branch candidates: if candidate[1:0] != 0:
  - pc is unchanged;
  - fault_address <= candidate;
  - misaligned <= 1;
  - state <= FAULT.
  - Otherwise pc <= candidate.
- FAULT:
  - Ignores stall, jump, branch and fetch_ready.
  - Exits only on trap: pc <= TRAP_VECTOR, misaligned <= 0, state <= RUN. fault_address retains its value.
- trap in BOOT: pc <= TRAP_VECTOR, state <= RUN.
- Arithmetic:
  - All sums are XLEN bits and wrap modulo 2^XLEN, with no carry-out or overflow flag. For example, pc = 2^XLEN - 4 advances to 0.
  - immediate is signed; the shift discards its MSB.
- Latency: every redirect is visible on program_counter the cycle after the qualifying edge. No combinational path from any input to program_counter, misaligned or fetch_valid.
- Reset asserted mid-operation (any state) returns all registers to their reset values immediately. Pending inputs are discarded.

Optional Feature:
- Macro: PROGRAM_COUNTER_COMPRESSED_EN.
- Defined:
  - Adds input port compressed (1 bit): the instruction at pc is 16-bit.
  - Sequential step is pc + 2 when compressed = 1, else pc + 4.
  - The alignment check tests candidate[0] only, so 2-byte-aligned targets are legal.
  - program_counter_plus_4 is unchanged.
- Undefined:
  - No compressed port.
  - Step is always 4.
  - 4-byte alignment is enforced as above.

Test Plan:
- Reset release with RESET_VECTOR = 0 and fetch_ready = 1: cycle 0 is BOOT (fetch_valid = 0, pc = 0); pc then reads 0, 4, 8, 12 on successive cycles.
- fetch_ready = 0 for 3 cycles at pc = 0x10: pc holds 0x10 and fetch_valid stays 1. Then branch = 1, immediate = -4 at pc = 0x10: pc becomes 0x8 next cycle regardless of fetch_ready.
- stall = 1 with jump = 1, jump_target = 0x41 at pc = 0x20: pc stays 0x20. Release stall with jump still asserted: pc becomes 0x40.
- jump_target = 0x42 (compressed disabled): misaligned = 1, fault_address = 0x42, fetch_valid = 0, pc unchanged. Branch, jump and stall are then ignored. trap = 1: pc becomes 0x100, misaligned = 0, fetch_valid = 1.
- XLEN = 8, pc = 0xFC, fetch handshake completes: pc wraps to 0x00 and program_counter_plus_4 reads 0x04. Assert reset asynchronously mid-cycle: pc = RESET_VECTOR immediately, without waiting for a clock edge.
- With PROGRAM_COUNTER_COMPRESSED_EN defined: compressed = 1 at pc = 0x0 gives 0x2, then compressed = 0 gives 0x6. jump_target = 0x2A does not fault and gives pc = 0x2A.
